// File: rtl/aes_io_pkg.sv
// Shared types for the AES256 core I/O path.
//   AES_BLK_BYTES : bytes per cipher block
//   byte_t        : one byte of block data
//   ctrl_state_t  : output-register sequencer states
package aes_io_pkg;

  localparam int unsigned AES_BLK_BYTES = 16;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/mod_outreg_ctrl.sv
// Sequencer for the 16-byte parallel-in / byte-serial-out output register.
// Accepts a finished block over blk_valid/blk_ready, pulses reg_wr_en on the
// accept edge, then requests one byte at a time from the register and holds
// each on byte_o until the downstream takes it.
//
// Ports:
//   clk           system clock, posedge
//   resetn        synchronous reset, active-high despite the name
//   blk_valid     upstream block valid (data sits on the register input)
//   blk_ready     controller can accept a block
//   flush         synchronous abort of the current block
//   reg_wr_en     register write enable (combinational with blk_valid)
//   reg_req       one-cycle byte request to the register
//   reg_o         byte from the register, valid the cycle after reg_req
//   reg_empty     register empty flag
//   byte_o        output byte
//   byte_valid    byte_o valid
//   byte_ready    downstream accepts byte_o
//   byte_last     current byte is the final byte of the block
//   busy          sequencer not idle
//   err_underflow sticky: register was empty while bytes were still owed
module mod_outreg_ctrl
  import aes_io_pkg::*;
#(
  parameter int unsigned NBYTES = AES_BLK_BYTES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       blk_valid,
  output logic       blk_ready,
  input  logic       flush,
  output logic       reg_wr_en,
  output logic       reg_req,
  input  logic [7:0] reg_o,
  input  logic       reg_empty,
  output logic [7:0] byte_o,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       byte_last,
  output logic       busy,
  output logic       err_underflow
);

  localparam int unsigned CW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  ctrl_state_t   state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (resetn) begin
      state         <= IDLE;
      cnt           <= '0;
      byte_o        <= '0;
      byte_valid    <= 1'b0;
      err_underflow <= 1'b0;
    end else if (flush && (state != IDLE)) begin
      // Abort wins over any handshake in the same cycle; the register keeps
      // its stale contents until the next accept overwrites them.
      state      <= IDLE;
      byte_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid) begin
            cnt   <= '0;
            state <= REQ;
          end
        end
        REQ: begin
          if (reg_empty) begin
            err_underflow <= 1'b1;
            state         <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          byte_o     <= reg_o;
          byte_valid <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (byte_ready) begin
            byte_valid <= 1'b0;
            if (cnt == LAST_IDX) begin
              state <= IDLE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write enable follows blk_valid combinationally so the register captures
  // the block on the same edge the controller accepts it.
  always_comb begin
    blk_ready = !resetn && (state == IDLE);
    reg_wr_en = blk_ready && blk_valid;
    reg_req   = !resetn && (state == REQ);
    busy      = (state != IDLE);
    byte_last = byte_valid && (cnt == LAST_IDX);
  end

endmodule
